// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR sample stream.
// Used by goldenmodel_fir_filter, its bench, and fir_decim_out_buffer.
//   DATA_W   : default sample width
//   sample_t : signed two's complement sample
//   phase_w  : width of a 0..decim-1 counter, never less than 1 bit
package fir_stream_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    function automatic int phase_w(input int decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous flush
//   push, din    : write request and data
//   pop          : read request; head advances at the edge
//   head         : oldest entry, 0 when empty
//   full, empty  : occupancy flags
//   level        : occupancy, 0..DEPTH
// A push while full succeeds only together with a pop.
// A pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// Decimating output buffer for the FIR sample stream.
// Keeps one sample per DECIM valid inputs, at phase PHASE.
// Kept samples queue in a FWFT FIFO with valid/ready on the output.
//   clk, reset_n          : clock, async active-low reset
//   clear                 : synchronous flush of phase, FIFO and drop stats
//   data_in, valid_in     : sample stream from the FIR; never stalled
//   data_out, valid_out   : FIFO head; data_out is 0 when empty
//   ready_in              : downstream pop enable
//   level                 : FIFO occupancy
//   overflow              : sticky flag for a dropped kept sample
//   drop_count            : saturating count of dropped samples
module fir_decim_out_buffer
    import fir_stream_pkg::*;
#(
    parameter int DATA_W     = fir_stream_pkg::DATA_W,
    parameter int DECIM      = 4,
    parameter int PHASE      = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     valid_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [LW-1:0]            level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int PW = phase_w(DECIM);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
    localparam logic [PW-1:0] KEEP_PHASE = PW'(PHASE);

    logic [PW-1:0] phase;
    logic          keep, pop, push, drop;
    logic          fifo_full, fifo_empty;

    assign keep      = valid_in && (phase == KEEP_PHASE);
    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_in;
    // A full FIFO still accepts a kept sample when a pop frees a slot.
    assign push      = keep && (!fifo_full || pop);
    assign drop      = keep && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            phase      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (valid_in)
                phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .din     (data_in),
        .pop     (pop),
        .head    (data_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Directed bench for fir_decim_out_buffer.
// Two instances share stimulus: PHASE=0 (u0) and PHASE=3 (u3), DECIM=4, depth 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_fir_decim_out_buffer;

    logic               clk = 1'b0;
    logic               reset_n, clear, valid_in, ready_in;
    logic signed [15:0] data_in;
    logic signed [15:0] d0, d3;
    logic               v0, v3, of0, of3;
    logic [3:0]         l0, l3;
    logic [15:0]        dc0, dc3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_decim_out_buffer #(.DATA_W(16), .DECIM(4), .PHASE(0), .FIFO_DEPTH(8), .CNT_W(16)) u0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
        .data_out(d0), .valid_out(v0), .ready_in(ready_in), .level(l0), .overflow(of0),
        .drop_count(dc0));

    fir_decim_out_buffer #(.DATA_W(16), .DECIM(4), .PHASE(3), .FIFO_DEPTH(8), .CNT_W(16)) u3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in), .valid_in(valid_in),
        .data_out(d3), .valid_out(v3), .ready_in(ready_in), .level(l3), .overflow(of3),
        .drop_count(dc3));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vi, input logic signed [15:0] d, input logic rdy, input logic clr);
        valid_in = vi;
        data_in  = d;
        ready_in = rdy;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " v0"},  32'(v0), 0);
        chk({tag, " d0"},  32'(d0), 0);
        chk({tag, " l0"},  32'(l0), 0);
        chk({tag, " of0"}, 32'(of0), 0);
        chk({tag, " dc0"}, 32'(dc0), 0);
        chk({tag, " v3"},  32'(v3), 0);
        chk({tag, " l3"},  32'(l3), 0);
    endtask

    logic signed [15:0] vec [8];

    initial begin
        reset_n = 1'b0; clear = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        reset_n = 1'b1;
        step(1'b0, 16'sd0, 1'b1, 1'b0);

        // Test 1: inputs 0..15, ready=1; kept sample visible one cycle after its edge.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i), 1'b1, 1'b0);
            chk($sformatf("t1 v0 i=%0d", i), 32'(v0), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("t1 d0 i=%0d", i), $signed(d0), (i % 4 == 0) ? i : 0);
            chk($sformatf("t1 v3 i=%0d", i), 32'(v3), (i % 4 == 3) ? 1 : 0);
            chk($sformatf("t1 d3 i=%0d", i), $signed(d3), (i % 4 == 3) ? i : 0);
        end

        // Test 2: extreme values at PHASE=3 kept slots.
        vec = '{16'sd100, 16'sd101, 16'sd102, -16'sd32768, 16'sd104, 16'sd105, 16'sd106, -16'sd1};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vec[i], 1'b1, 1'b0);
            chk($sformatf("t2 d0 i=%0d", i), $signed(d0), (i == 0) ? 100 : (i == 4) ? 104 : 0);
            chk($sformatf("t2 d3 i=%0d", i), $signed(d3), (i == 3) ? -32768 : (i == 7) ? -1 : 0);
            chk($sformatf("t2 v3 i=%0d", i), 32'(v3), (i % 4 == 3) ? 1 : 0);
        end
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk("t2 final l0", 32'(l0), 0);
        chk("t2 final of0", 32'(of0), 0);
        chk("t2 final l3", 32'(l3), 0);

        // Test 3: overflow with ready=0, then drain in order.
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++)
            step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("t3 level", 32'(l0), 8);
        chk("t3 overflow", 32'(of0), 1);
        chk("t3 drop_count", 32'(dc0), 2);
        chk("t3 drop_count u3", 32'(dc3), 2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3 drain v k=%0d", k), 32'(v0), 1);
            chk($sformatf("t3 drain d k=%0d", k), $signed(d0), 4 * k);
            step(1'b0, 16'sd0, 1'b1, 1'b0);
        end
        chk("t3 empty v0", 32'(v0), 0);
        chk("t3 empty d0", $signed(d0), 0);
        chk("t3 empty l0", 32'(l0), 0);
        chk("t3 overflow sticky", 32'(of0), 1);
        // Empty with ready=1 must not underflow.
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk("t3 no underflow", 32'(l0), 0);

        // Test 4: full + kept sample + pop in the same cycle.
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        chk("t4 clear of0", 32'(of0), 0);
        chk("t4 clear dc0", 32'(dc0), 0);
        for (int i = 0; i < 32; i++)
            step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("t4 full level", 32'(l0), 8);
        chk("t4 full dc0", 32'(dc0), 0);
        step(1'b1, 16'sd1000, 1'b1, 1'b0);
        chk("t4 level held", 32'(l0), 8);
        chk("t4 no drop", 32'(dc0), 0);
        chk("t4 no overflow", 32'(of0), 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4 drain d k=%0d", k), $signed(d0), (k == 7) ? 1000 : 4 * (k + 1));
            step(1'b0, 16'sd0, 1'b1, 1'b0);
        end
        chk("t4 drained", 32'(v0), 0);

        // Test 5: clear with one entry buffered and phase=2.
        step(1'b0, 16'sd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'(50 + i), (i < 4) ? 1'b1 : 1'b0, 1'b0);
        chk("t5 level before", 32'(l0), 1);
        chk("t5 head before", $signed(d0), 54);
        step(1'b1, 16'sd77, 1'b1, 1'b1);
        chk("t5 clear v0", 32'(v0), 0);
        chk("t5 clear l0", 32'(l0), 0);
        step(1'b1, 16'sd88, 1'b0, 1'b0);
        chk("t5 kept v0", 32'(v0), 1);
        chk("t5 kept d0", $signed(d0), 88);
        step(1'b1, 16'sd89, 1'b0, 1'b0);
        chk("t5 not kept", 32'(l0), 1);

        // Test 6: async reset between edges mid-burst.
        step(1'b1, 16'sd90, 1'b0, 1'b0);
        step(1'b1, 16'sd91, 1'b0, 1'b0);
        step(1'b1, 16'sd92, 1'b0, 1'b0);
        chk("t6 pre level", 32'(l0), 2);
        #2;
        reset_n = 1'b0;
        #1;
        all_zero("t6 async");
        step(1'b1, 16'sd93, 1'b0, 1'b0);
        chk("t6 held l0", 32'(l0), 0);
        reset_n = 1'b1;
        step(1'b1, 16'sd123, 1'b0, 1'b0);
        chk("t6 first kept v0", 32'(v0), 1);
        chk("t6 first kept d0", $signed(d0), 123);
        chk("t6 first kept l3", 32'(l3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
